led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Command-driven sequencer for the board LED. It accepts steady, blink and PWM-dim patterns over a valid/ready command port and drives the single `led` output. The patterns are timed from a prescaled tick derived from `clk`. It sits between the host-side command logic and the LED pin, replacing free-running blink counters.

## Interface
- `TICK_DIV`, 50000: `clk` cycles per pattern tick; 1 ms at 50 MHz. Minimum 2.
- `CNT_W`, 16: width of the on/off tick counts.
- `REP_W`, 8: width of the blink repeat count.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_mode`  in  2: 0 = OFF, 1 = ON, 2 = BLINK, 3 = PWM.
- `cmd_on_ticks`  in  CNT_W: BLINK on-phase length in ticks. In PWM mode, bits [7:0] are the duty.
- `cmd_off_ticks`  in  CNT_W: BLINK off-phase length in ticks.
- `cmd_repeat`  in  REP_W: number of BLINK on/off cycles; 0 = forever.
- `led`  out  1: registered LED drive.
- `busy`  out  1: a finite BLINK is in progress.
- `done`  out  1: one-cycle pulse when a finite BLINK completes.

## Operation
- A command is accepted on any cycle where `cmd_valid && cmd_ready`. All command fields are latched on that cycle.
- `cmd_ready` is 1 in IDLE, STEADY, PWM, and in BLINK when repeat = 0. It is 0 during a finite BLINK (`busy` = 1).
  - A new command therefore preempts a steady, PWM or infinite pattern.
  - A finite blink cannot be preempted except by `rst`.
- States: IDLE, STEADY, PWM, BLK_ON, BLK_OFF.
- Transitions on accept:
  - OFF goes to IDLE with `led` = 0.
  - ON goes to STEADY with `led` = 1.
  - PWM goes to PWM.
  - BLINK goes to BLK_ON with `led` = 1.
- BLK_ON: the phase counter loads on_ticks. On the last tick, go to BLK_OFF with `led` = 0 and load off_ticks.
- BLK_OFF: on the last tick, either
  - if repeat = 0, or the remaining cycle count > 1: decrement the count (when finite) and go to BLK_ON; or
  - otherwise go to IDLE, pulse `done`, and drop `busy`.
- Zero on_ticks or off_ticks is treated as 1. Phases are never zero length.
- PWM: an 8-bit counter increments every `clk` and wraps 255 to 0. `led` = (pwm_cnt < duty).
  - duty 0 gives `led` constantly 0.
  - duty 255 gives 255/256 high.
  - pwm_cnt clears on accept.
- The prescaler clears on every accepted command, so the first tick falls exactly TICK_DIV cycles after accept.
- The prescaler free-runs in all states. Only BLK_* consume ticks.
- Reset (at any time, including mid-blink) gives:
  - state IDLE;
  - `led` = 0, `busy` = 0, `done` = 0, `cmd_ready` = 1;
  - all counters 0;
  - latched command discarded.

## Timing
- Accept at edge N: `led` reflects the new mode from cycle N+1. `busy` rises at N+1 for a finite BLINK.
- BLINK on-phase: `led` high for exactly on_ticks × TICK_DIV cycles. Off-phase: off_ticks × TICK_DIV cycles. No gap cycles between phases.
- `done` is asserted in the same cycle that `led` has entered the IDLE value and `busy` = 0. `cmd_ready` = 1 in that same cycle.
- A command presented in the `done` cycle is accepted. Its effect appears one cycle later, as usual.
- `cmd_ready` is combinational from state only, never from `cmd_valid`.
- Counter arithmetic is unsigned. The phase counter decrements to 1, then reloads. The repeat counter never underflows.

## Structure
- Package `led_ctrl_pkg` holds:
  - the mode encodings (OFF/ON/BLINK/PWM);
  - the state enum (IDLE/STEADY/PWM/BLK_ON/BLK_OFF);
  - the PWM width constant (8).
- Sub-module `tick_prescaler` (params TICK_DIV; ports clk, rst, clr, tick) contains:
  - a counter 0..TICK_DIV-1;
  - a one-cycle `tick` pulse on the count of TICK_DIV-1;
  - `clr` has priority over counting.
- The top contains the FSM, the phase/repeat counters and the PWM counter. `led` is a flop, with no combinational path from the inputs.

## Test plan
All scenarios use TICK_DIV = 4, with clk period 20.
- Reset mid-blink: start BLINK on = 3, off = 2, repeat = 5, then assert `rst` for 1 cycle at cycle 17. Expect `led` = 0, `busy` = 0, `cmd_ready` = 1 on the next cycle, and no `done`.
- Finite blink: BLINK on = 3, off = 2, repeat = 2. Expect:
  - `led` high for 12 cycles, low 8, high 12, low 8;
  - `done` exactly once, 40 cycles after accept + 1;
  - `cmd_ready` = 0 throughout.
- Preempt infinite blink: BLINK on = 2, off = 2, repeat = 0, then an ON command at cycle 11. Expect `led` = 1 from cycle 12 and held, with no `done`.
- Zero-length phases: BLINK on = 0, off = 0, repeat = 1. Expect `led` high 4 cycles, low 4 cycles, then `done`.
- PWM: duty = 64 for 1024 cycles. Expect exactly 256 high cycles. duty = 0 gives 0 high cycles; duty = 255 gives 1020 high cycles.
- Back-to-back commands: `cmd_valid` held during the `done` cycle with OFF. Expect acceptance in that cycle and `led` = 0 the next cycle.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED sequencer.
//   mode_e  : command mode field encodings (OFF/ON/BLINK/PWM)
//   state_e : sequencer FSM states
//   PWM_W   : width of the PWM duty/counter
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEADY,
    ST_PWM,
    ST_BLK_ON,
    ST_BLK_OFF
  } state_e;

  localparam int unsigned PWM_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick pulse every TICK_DIV cycles.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : restart the count from 0 (wins over counting)
//   tick : high while the count sits at TICK_DIV-1
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: steady, blink and PWM-dim patterns.
//   clk, rst      : clock, synchronous active-high reset
//   cmd_valid     : command present
//   cmd_ready     : command can be accepted (low only during a finite blink)
//   cmd_mode      : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cmd_on_ticks  : blink on-phase ticks; [7:0] is the PWM duty
//   cmd_off_ticks : blink off-phase ticks
//   cmd_repeat    : blink cycles, 0 = forever
//   led           : registered LED drive
//   busy          : finite blink in progress
//   done          : one-cycle pulse when a finite blink completes
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned REP_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_on_ticks,
  input  logic [CNT_W-1:0] cmd_off_ticks,
  input  logic [REP_W-1:0] cmd_repeat,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_e             state, state_n;
  logic               led_n, done_n;
  logic [CNT_W-1:0]   phase, phase_n;
  logic [REP_W-1:0]   rep, rep_n;
  logic               rep_inf, rep_inf_n;
  logic [CNT_W-1:0]   on_lat, on_lat_n;
  logic [CNT_W-1:0]   off_lat, off_lat_n;
  logic [PWM_W-1:0]   duty, duty_n;
  logic [PWM_W-1:0]   pwm_cnt, pwm_n;
  logic               tick;
  logic               accept;

  // Phases are never zero length: a zero count behaves as one tick.
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign busy      = ((state == ST_BLK_ON) || (state == ST_BLK_OFF)) && !rep_inf;
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );

  always_comb begin
    state_n   = state;
    led_n     = led;
    done_n    = 1'b0;
    phase_n   = phase;
    rep_n     = rep;
    rep_inf_n = rep_inf;
    on_lat_n  = on_lat;
    off_lat_n = off_lat;
    duty_n    = duty;
    pwm_n     = pwm_cnt;

    case (state)
      ST_PWM: begin
        pwm_n = pwm_cnt + 1'b1;
        led_n = (pwm_n < duty);
      end
      ST_BLK_ON: begin
        if (tick) begin
          if (phase == CNT_W'(1)) begin
            state_n = ST_BLK_OFF;
            led_n   = 1'b0;
            phase_n = nz(off_lat);
          end else begin
            phase_n = phase - 1'b1;
          end
        end
      end
      ST_BLK_OFF: begin
        if (tick) begin
          if (phase == CNT_W'(1)) begin
            if (rep_inf || (rep > REP_W'(1))) begin
              if (!rep_inf) rep_n = rep - 1'b1;
              state_n = ST_BLK_ON;
              led_n   = 1'b1;
              phase_n = nz(on_lat);
            end else begin
              state_n = ST_IDLE;
              led_n   = 1'b0;
              done_n  = 1'b1;
              phase_n = '0;
              rep_n   = '0;
            end
          end else begin
            phase_n = phase - 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Acceptance overrides the running pattern; a finite blink never
    // completes in an accept cycle because cmd_ready is low then.
    if (accept) begin
      on_lat_n  = cmd_on_ticks;
      off_lat_n = cmd_off_ticks;
      duty_n    = cmd_on_ticks[PWM_W-1:0];
      pwm_n     = '0;
      phase_n   = '0;
      rep_n     = '0;
      rep_inf_n = 1'b0;
      case (mode_e'(cmd_mode))
        MODE_OFF: begin
          state_n = ST_IDLE;
          led_n   = 1'b0;
        end
        MODE_ON: begin
          state_n = ST_STEADY;
          led_n   = 1'b1;
        end
        MODE_PWM: begin
          state_n = ST_PWM;
          led_n   = (cmd_on_ticks[PWM_W-1:0] != '0);
        end
        default: begin
          state_n   = ST_BLK_ON;
          led_n     = 1'b1;
          phase_n   = nz(cmd_on_ticks);
          rep_n     = cmd_repeat;
          rep_inf_n = (cmd_repeat == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      led     <= 1'b0;
      done    <= 1'b0;
      phase   <= '0;
      rep     <= '0;
      rep_inf <= 1'b0;
      on_lat  <= '0;
      off_lat <= '0;
      duty    <= '0;
      pwm_cnt <= '0;
    end else begin
      state   <= state_n;
      led     <= led_n;
      done    <= done_n;
      phase   <= phase_n;
      rep     <= rep_n;
      rep_inf <= rep_inf_n;
      on_lat  <= on_lat_n;
      off_lat <= off_lat_n;
      duty    <= duty_n;
      pwm_cnt <= pwm_n;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_on_ticks;
  logic [15:0] cmd_off_ticks;
  logic [7:0]  cmd_repeat;
  logic        led;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int hi;

  led_seq_ctrl #(
    .TICK_DIV(4),
    .CNT_W   (16),
    .REP_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_on_ticks (cmd_on_ticks),
    .cmd_off_ticks(cmd_off_ticks),
    .cmd_repeat   (cmd_repeat),
    .led          (led),
    .busy         (busy),
    .done         (done)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a command for exactly one edge; returns sampled just after it.
  task automatic send(input logic [1:0] m, input logic [15:0] on_t,
                      input logic [15:0] off_t, input logic [7:0] r);
    cmd_valid     = 1'b1;
    cmd_mode      = m;
    cmd_on_ticks  = on_t;
    cmd_off_ticks = off_t;
    cmd_repeat    = r;
    step();
    cmd_valid     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0;
    cmd_on_ticks = '0; cmd_off_ticks = '0; cmd_repeat = '0;
    step(); step(); step();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    step();

    // Steady ON then OFF
    send(2'd1, 16'd0, 16'd0, 8'd0);
    chk("on_led", led, 1);
    chk("on_ready", cmd_ready, 1);
    step(); step();
    chk("on_hold", led, 1);
    send(2'd0, 16'd0, 16'd0, 8'd0);
    chk("off_led", led, 0);

    // Reset mid-blink: accept at N, rst during cycle N+17
    send(2'd2, 16'd3, 16'd2, 8'd5);
    chk("rmb_busy", busy, 1);
    chk("rmb_ready", cmd_ready, 0);
    for (int k = 1; k < 17; k++) step();
    chk("rmb_led_pre", led, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmb_led", led, 0);
    chk("rmb_busy_after", busy, 0);
    chk("rmb_ready_after", cmd_ready, 1);
    chk("rmb_done", done, 0);
    hi = 0;
    for (int k = 0; k < 60; k++) begin
      hi += int'(done) + int'(led);
      step();
    end
    chk("rmb_quiet", hi, 0);

    // Finite blink 3/2 x2: 12 high, 8 low, 12 high, 8 low, then done
    send(2'd2, 16'd3, 16'd2, 8'd2);
    for (int k = 0; k < 40; k++) begin
      chk("fb_led", led, ((k < 12) || (k >= 20 && k < 32)) ? 1 : 0);
      chk("fb_ready", cmd_ready, 0);
      chk("fb_busy", busy, 1);
      chk("fb_done_early", done, 0);
      step();
    end
    chk("fb_done", done, 1);
    chk("fb_done_led", led, 0);
    chk("fb_done_busy", busy, 0);
    chk("fb_done_ready", cmd_ready, 1);
    // ON presented in the done cycle is accepted
    send(2'd1, 16'd0, 16'd0, 8'd0);
    chk("fb_b2b_led", led, 1);
    chk("fb_done_drop", done, 0);

    // Infinite blink 2/2, preempted by ON at cycle N+11
    send(2'd2, 16'd2, 16'd2, 8'd0);
    for (int k = 0; k < 10; k++) begin
      chk("inf_led", led, (k < 8) ? 1 : 0);
      chk("inf_ready", cmd_ready, 1);
      chk("inf_busy", busy, 0);
      step();
    end
    send(2'd1, 16'd0, 16'd0, 8'd0);
    hi = 0;
    for (int k = 0; k < 24; k++) begin
      hi += int'(led) - int'(done);
      step();
    end
    chk("pre_on_held", hi, 24);

    // Zero-length phases: 4 high, 4 low, done; OFF in done cycle
    send(2'd2, 16'd0, 16'd0, 8'd1);
    for (int k = 0; k < 8; k++) begin
      chk("zl_led", led, (k < 4) ? 1 : 0);
      chk("zl_done_early", done, 0);
      step();
    end
    chk("zl_done", done, 1);
    chk("zl_ready", cmd_ready, 1);
    send(2'd0, 16'd0, 16'd0, 8'd0);
    chk("b2b_off_led", led, 0);
    chk("b2b_off_done", done, 0);
    chk("b2b_off_busy", busy, 0);

    // PWM duty 64 / 0 / 255 over 1024 cycles
    send(2'd3, 16'd64, 16'd0, 8'd0);
    hi = 0;
    for (int k = 0; k < 1024; k++) begin hi += int'(led); step(); end
    chk("pwm64_high", hi, 256);
    send(2'd3, 16'd0, 16'd0, 8'd0);
    hi = 0;
    for (int k = 0; k < 1024; k++) begin hi += int'(led); step(); end
    chk("pwm0_high", hi, 0);
    send(2'd3, 16'd255, 16'd0, 8'd0);
    hi = 0;
    for (int k = 0; k < 1024; k++) begin hi += int'(led); step(); end
    chk("pwm255_high", hi, 1020);
    chk("pwm_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
